// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg
//   Shared types and helpers for the FIR result readout sequencer.
//   seq_state_t : readout FSM states
//   clog2_min1  : ceil(log2(n)) clamped to a minimum of 1 bit, for
//                 sizing counters whose range may collapse to a single value
package fir_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        READ,
        CAPTURE,
        OUT,
        FINISH
    } seq_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rd_lat_counter.sv
// rd_lat_counter
//   Loadable down-counter that times the register-read latency of fir_top.
//   clk     : clock, rising edge
//   reset   : asynchronous active-high, clears the count
//   load    : load loadVal this edge (takes priority over counting)
//   loadVal : value to load
//   zero    : count currently reads 0
//   Once loaded the counter runs down to 0 and parks there.
module rd_lat_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fir_result_sequencer.sv
// fir_result_sequencer
//   Reads NUM_WORDS result words from fir_top's register-read port once a
//   filter run is done, and streams them out on a valid/ready interface.
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   start               : 1-cycle pulse arming a frame (only honoured in IDLE)
//   abort               : synchronous abort back to IDLE, wins over start
//   firDone             : fir_top done level, sampled only while ARMED
//   regAddr / regData   : register-read port into fir_top
//   outValid/outReady   : output handshake
//   outData / outLast   : result word and final-word marker
//   busy                : high in every state except IDLE
//   frameDone           : 1-cycle pulse following the last word handshake
//   All outputs are registered.
module fir_result_sequencer
    import fir_seq_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter longint unsigned BASE_ADDR = 0,
    parameter int              NUM_WORDS = 8,
    parameter int              RD_LAT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              firDone,
    output logic [ADDR_W-1:0] regAddr,
    input  logic [DATA_W-1:0] regData,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic              outLast,
    output logic              busy,
    output logic              frameDone
);

    localparam int IW = $clog2(NUM_WORDS + 1);
    localparam int CW = clog2_min1(RD_LAT + 1);
    localparam longint unsigned LAST_ADDR = BASE_ADDR + 64'(NUM_WORDS) - 64'd1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    if (NUM_WORDS < 1) begin : g_bad_num_words
        $error("fir_result_sequencer: NUM_WORDS must be >= 1");
    end
    if (ADDR_W < 64 && (LAST_ADDR >> ADDR_W) != 64'd0) begin : g_bad_addr_range
        $error("fir_result_sequencer: BASE_ADDR+NUM_WORDS-1 exceeds ADDR_W");
    end

    seq_state_t      state;
    logic [IW-1:0]   idx;
    logic            latLoad;
    logic            latZero;

    // Counter is loaded on the READ edge, so the first CAPTURE edge already
    // sees RD_LAT; RD_LAT=0 captures immediately.
    assign latLoad = (state == READ);

    rd_lat_counter #(
        .WIDTH (CW)
    ) u_lat (
        .clk     (clk),
        .reset   (reset),
        .load    (latLoad),
        .loadVal (CW'(RD_LAT)),
        .zero    (latZero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            regAddr   <= BASE;
            outValid  <= 1'b0;
            outData   <= '0;
            outLast   <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            idx       <= '0;
            regAddr   <= BASE;
            outValid  <= 1'b0;
            outLast   <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                IDLE: begin
                    regAddr <= BASE;
                    if (start) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (firDone) state <= READ;
                end
                READ: begin
                    regAddr <= BASE + ADDR_W'(idx);
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    if (latZero) begin
                        outData  <= regData;
                        outLast  <= (idx == IW'(NUM_WORDS - 1));
                        outValid <= 1'b1;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        outLast  <= 1'b0;
                        if (idx == IW'(NUM_WORDS - 1)) begin
                            // Pulse is raised entering FINISH so it appears
                            // the cycle right after the last handshake.
                            frameDone <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= READ;
                        end
                    end
                end
                FINISH: begin
                    idx     <= '0;
                    regAddr <= BASE;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_result_sequencer.sv
// tb_fir_result_sequencer
//   Self-checking bench for fir_result_sequencer. Three instances cover
//   RD_LAT=0 (NUM_WORDS=4), RD_LAT=2 with a non-zero base (NUM_WORDS=4) and
//   a single-word frame. One instance is exercised at a time via sel.
module tb_fir_result_sequencer;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, firDone, outReady;
    logic [1:0]  sel;

    logic        st_i [NI];
    logic        ab_i [NI];
    logic        fd_i [NI];
    logic        rdy_i [NI];
    logic [31:0] addr_o [NI];
    logic [31:0] data_i [NI];
    logic [31:0] dout_o [NI];
    logic        val_o [NI];
    logic        last_o [NI];
    logic        busy_o [NI];
    logic        fdone_o [NI];

    logic        v_valid, v_last, v_busy, v_frameDone;
    logic [31:0] v_data, v_addr;

    int nchecks = 0;
    int nfail   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_gate
        assign st_i[k]  = start    && (sel == k);
        assign ab_i[k]  = abort    && (sel == k);
        assign fd_i[k]  = firDone  && (sel == k);
        assign rdy_i[k] = outReady && (sel == k);
    end

    // Result memory model: word at address a is 0xA0 + a.
    assign data_i[0] = 32'hA0 + addr_o[0];
    assign data_i[2] = 32'hA0 + addr_o[2];
    logic [31:0] pipe1, pipe2;
    always @(posedge clk) begin
        pipe1 <= 32'hA0 + addr_o[1];
        pipe2 <= pipe1;
    end
    assign data_i[1] = pipe2;

    fir_result_sequencer #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(0),
                           .NUM_WORDS(4), .RD_LAT(0)) u_lat0 (
        .clk(clk), .reset(reset), .start(st_i[0]), .abort(ab_i[0]), .firDone(fd_i[0]),
        .regAddr(addr_o[0]), .regData(data_i[0]), .outValid(val_o[0]), .outReady(rdy_i[0]),
        .outData(dout_o[0]), .outLast(last_o[0]), .busy(busy_o[0]), .frameDone(fdone_o[0]));

    fir_result_sequencer #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(64'h40),
                           .NUM_WORDS(4), .RD_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .start(st_i[1]), .abort(ab_i[1]), .firDone(fd_i[1]),
        .regAddr(addr_o[1]), .regData(data_i[1]), .outValid(val_o[1]), .outReady(rdy_i[1]),
        .outData(dout_o[1]), .outLast(last_o[1]), .busy(busy_o[1]), .frameDone(fdone_o[1]));

    fir_result_sequencer #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(7),
                           .NUM_WORDS(1), .RD_LAT(0)) u_one (
        .clk(clk), .reset(reset), .start(st_i[2]), .abort(ab_i[2]), .firDone(fd_i[2]),
        .regAddr(addr_o[2]), .regData(data_i[2]), .outValid(val_o[2]), .outReady(rdy_i[2]),
        .outData(dout_o[2]), .outLast(last_o[2]), .busy(busy_o[2]), .frameDone(fdone_o[2]));

    always_comb begin
        v_valid     = val_o[sel];
        v_last      = last_o[sel];
        v_busy      = busy_o[sel];
        v_frameDone = fdone_o[sel];
        v_data      = dout_o[sel];
        v_addr      = addr_o[sel];
    end

    function automatic int nw_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic int base_of(input int k);
        return (k == 1) ? 32'h40 : ((k == 2) ? 7 : 0);
    endfunction

    function automatic logic [31:0] word_at(input int k, input int i);
        return 32'hA0 + 32'(base_of(k)) + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete frame on instance k. mode 0: ready always high,
    // 1: six stall cycles on word 1, 2: random ready plus firDone dropping.
    task automatic frame(input int k, input int mode, input int armed_cycles);
        int t, first_v, last_hs, got, stalls, err;
        bit done_seen, prev_stall, hs;
        logic [31:0] pdata, paddr;
        logic plast;
        sel = 2'(k); outReady = 1'b0; firDone = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        err = 0;
        for (int i = 0; i < armed_cycles; i++) begin
            if (!v_busy || v_valid || v_addr !== 32'(base_of(k))) err++;
            start = (i == 1);
            tick();
        end
        start = 1'b0;
        chk("armed_hold", err, 0);
        firDone = 1'b1;
        t = 0; first_v = -1; last_hs = -1; got = 0; stalls = 0;
        done_seen = 0; prev_stall = 0; pdata = '0; paddr = '0; plast = 1'b0;
        while (!done_seen && t < 300) begin
            case (mode)
                0: outReady = 1'b1;
                1: begin
                    outReady = 1'b1;
                    if (v_valid && got == 1 && stalls < 6) begin
                        outReady = 1'b0;
                        stalls++;
                    end
                end
                default: outReady = ($urandom_range(0, 3) != 0);
            endcase
            start = (t == 2 || t == 7);
            if (mode == 2 && t == 8) firDone = 1'b0;
            if (prev_stall) begin
                chk("stall_valid", v_valid, 1);
                chk("stall_data", v_data, pdata);
                chk("stall_last", v_last, plast);
                chk("stall_addr", v_addr, paddr);
            end
            if (v_valid && first_v < 0) begin
                first_v = t;
                chk("first_valid_latency", t, 3 + lat_of(k));
            end
            if (v_frameDone) begin
                done_seen = 1;
                chk("done_after_last", t, last_hs + 1);
                chk("words_per_frame", got, nw_of(k));
            end
            if (v_valid) chk("addr_during_valid", v_addr, base_of(k) + got);
            hs = v_valid && outReady;
            if (hs) begin
                chk("word_data", v_data, word_at(k, got));
                chk("word_last", v_last, (got == nw_of(k) - 1));
                if (mode == 0 && last_hs >= 0) chk("word_spacing", t - last_hs, 3 + lat_of(k));
                got++;
                last_hs = t;
            end
            prev_stall = v_valid && !outReady;
            pdata = v_data; plast = v_last; paddr = v_addr;
            tick();
            t++;
        end
        start = 1'b0; outReady = 1'b0; firDone = 1'b0;
        chk("frame_completed", done_seen, 1);
        chk("busy_after_done", v_busy, 0);
        chk("done_single_cycle", v_frameDone, 0);
        err = 0;
        for (int i = 0; i < 6; i++) begin
            if (v_busy || v_valid || v_frameDone || v_addr !== 32'(base_of(k))) err++;
            tick();
        end
        chk("idle_after_frame", err, 0);
    endtask

    task automatic abort_test(input int k);
        int t, got, err;
        bit found;
        sel = 2'(k); start = 1'b1; tick(); start = 1'b0;
        firDone = 1'b1; got = 0; found = 0; t = 0;
        while (!found && t < 100) begin
            if (v_valid && got == 2) begin
                found = 1;
            end else begin
                outReady = 1'b1;
                if (v_valid) got++;
                tick();
                t++;
            end
        end
        chk("abort_reached_word2", found, 1);
        outReady = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; firDone = 1'b0;
        chk("abort_valid", v_valid, 0);
        chk("abort_busy", v_busy, 0);
        chk("abort_addr", v_addr, base_of(k));
        err = 0;
        for (int i = 0; i < 5; i++) begin
            if (v_frameDone || v_busy) err++;
            tick();
        end
        chk("abort_no_frameDone", err, 0);
    endtask

    task automatic reset_in_capture(input int k);
        int t;
        bit found;
        sel = 2'(k); start = 1'b1; tick(); start = 1'b0;
        firDone = 1'b1; outReady = 1'b1; found = 0; t = 0;
        while (!found && t < 100) begin
            if (!v_valid && v_busy && v_addr == 32'(base_of(k) + 1)) found = 1;
            else begin tick(); t++; end
        end
        chk("reached_capture", found, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", v_valid, 0);
        chk("rst_busy", v_busy, 0);
        chk("rst_addr", v_addr, base_of(k));
        chk("rst_data", v_data, 0);
        chk("rst_last", v_last, 0);
        chk("rst_frameDone", v_frameDone, 0);
        firDone = 1'b0; outReady = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int err;
        sel = 2'd0; start = 1'b0; abort = 1'b0; firDone = 1'b0; outReady = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("reset_addr", addr_o[k], base_of(k));
            chk("reset_valid", val_o[k], 0);
            chk("reset_data", dout_o[k], 0);
            chk("reset_last", last_o[k], 0);
            chk("reset_busy", busy_o[k], 0);
            chk("reset_frameDone", fdone_o[k], 0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        frame(0, 0, 5);
        frame(0, 1, 3);
        frame(1, 0, 2);
        frame(1, 1, 2);
        for (int r = 0; r < 3; r++) begin
            frame(0, 2, 1 + r);
            frame(1, 2, 2 + r);
        end

        abort_test(0);
        frame(0, 0, 2);

        reset_in_capture(1);
        frame(1, 0, 2);

        // start and abort together in IDLE: abort wins
        sel = 2'd0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        err = 0;
        for (int i = 0; i < 4; i++) begin
            if (v_busy) err++;
            tick();
        end
        chk("start_abort_stays_idle", err, 0);

        frame(0, 0, 100);
        frame(2, 0, 3);
        frame(2, 2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
